// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: exception bit map, cause codes, FSM states.
package trap_pkg;

  localparam int EXC_W   = 7;
  localparam int CAUSE_W = 5;

  localparam int EXC_LD_MISALIGN = 0;
  localparam int EXC_LD_PAGE     = 1;
  localparam int EXC_ST_MISALIGN = 2;
  localparam int EXC_ST_PAGE     = 3;
  localparam int EXC_ILLEGAL     = 4;
  localparam int EXC_ECALL       = 5;
  localparam int EXC_BREAKPOINT  = 6;

  localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_LD_PAGE     = 5'd13;
  localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_ST_PAGE     = 5'd15;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL       = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT  = 5'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    REDIR = 2'd2,
    RET   = 2'd3
  } trap_state_e;

endpackage

// File: rtl/trap_sequencer_if.sv
// Exception-detector / CSR / PC-mux bundle seen by the trap sequencer.
interface trap_sequencer_if import trap_pkg::*; #(parameter int N = 64);

  logic [EXC_W-1:0] exc_F;
  logic [EXC_W-1:0] exc_D;
  logic [EXC_W-1:0] exc_E;
  logic [N-1:0]     pc_F;
  logic [N-1:0]     pc_D;
  logic [N-1:0]     pc_E;
  logic [N-1:0]     addr_E;
  logic             mret_E;
  logic [N-1:0]     mtvec;
  logic [N-1:0]     mepc_q;
  logic             redir_ready;
  logic             flush;
  logic             stall;
  logic             csr_we;
  logic [N-1:0]     mepc_d;
  logic [N-1:0]     mcause_d;
  logic [N-1:0]     mtval_d;
  logic             redir_valid;
  logic [N-1:0]     redir_pc;
  logic             busy;

  modport slave (
    input  exc_F, exc_D, exc_E, pc_F, pc_D, pc_E, addr_E, mret_E,
           mtvec, mepc_q, redir_ready,
    output flush, stall, csr_we, mepc_d, mcause_d, mtval_d,
           redir_valid, redir_pc, busy
  );

  modport master (
    output exc_F, exc_D, exc_E, pc_F, pc_D, pc_E, addr_E, mret_E,
           mtvec, mepc_q, redir_ready,
    input  flush, stall, csr_we, mepc_d, mcause_d, mtval_d,
           redir_valid, redir_pc, busy
  );

endinterface

// File: rtl/trap_sequencer_exc_prio_enc.sv
// Per-stage priority encoder: picks the highest-priority exception bit and maps it to a cause.
module exc_prio_enc
  import trap_pkg::*;
(
  input  logic [EXC_W-1:0]   exc_i,
  output logic               valid_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic               uses_addr_o
);

  // Priority b6 > b4 > b5 > b2 > b0 > b3 > b1; misaligned beats page fault.
  always_comb begin
    valid_o     = |exc_i;
    cause_o     = 5'd0;
    uses_addr_o = 1'b0;
    if (exc_i[EXC_BREAKPOINT]) begin
      cause_o = CAUSE_BREAKPOINT;
    end else if (exc_i[EXC_ILLEGAL]) begin
      cause_o = CAUSE_ILLEGAL;
    end else if (exc_i[EXC_ECALL]) begin
      cause_o = CAUSE_ECALL;
    end else if (exc_i[EXC_ST_MISALIGN]) begin
      cause_o     = CAUSE_ST_MISALIGN;
      uses_addr_o = 1'b1;
    end else if (exc_i[EXC_LD_MISALIGN]) begin
      cause_o     = CAUSE_LD_MISALIGN;
      uses_addr_o = 1'b1;
    end else if (exc_i[EXC_ST_PAGE]) begin
      cause_o     = CAUSE_ST_PAGE;
      uses_addr_o = 1'b1;
    end else if (exc_i[EXC_LD_PAGE]) begin
      cause_o     = CAUSE_LD_PAGE;
      uses_addr_o = 1'b1;
    end else begin
      cause_o     = 5'd0;
      uses_addr_o = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Precise trap / mret sequencer. Define TRAP_MTVAL_EN to produce a real mtval; otherwise mtval is 0.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           reset,
  trap_sequencer_if.slave bus
);

  logic               f_valid_s, d_valid_s, e_valid_s;
  logic [CAUSE_W-1:0] f_cause_s, d_cause_s, e_cause_s;
  logic               f_addr_s, d_addr_s, e_addr_s;

  exc_prio_enc u_enc_f (.exc_i(bus.exc_F), .valid_o(f_valid_s), .cause_o(f_cause_s), .uses_addr_o(f_addr_s));
  exc_prio_enc u_enc_d (.exc_i(bus.exc_D), .valid_o(d_valid_s), .cause_o(d_cause_s), .uses_addr_o(d_addr_s));
  exc_prio_enc u_enc_e (.exc_i(bus.exc_E), .valid_o(e_valid_s), .cause_o(e_cause_s), .uses_addr_o(e_addr_s));

  logic               sel_valid_s;
  logic [CAUSE_W-1:0] sel_cause_s;
  logic               sel_addr_s;
  logic [N-1:0]       sel_pc_s;

  // Oldest faulting stage wins: E, then D, then F.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_cause_s = 5'd0;
    sel_addr_s  = 1'b0;
    sel_pc_s    = '0;
    if (e_valid_s) begin
      sel_valid_s = 1'b1;
      sel_cause_s = e_cause_s;
      sel_addr_s  = e_addr_s;
      sel_pc_s    = bus.pc_E;
    end else if (d_valid_s) begin
      sel_valid_s = 1'b1;
      sel_cause_s = d_cause_s;
      sel_addr_s  = d_addr_s;
      sel_pc_s    = bus.pc_D;
    end else if (f_valid_s) begin
      sel_valid_s = 1'b1;
      sel_cause_s = f_cause_s;
      sel_addr_s  = f_addr_s;
      sel_pc_s    = bus.pc_F;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  trap_state_e state_q, state_d;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; anything arriving outside IDLE is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_valid_s)     state_d = SAVE;
        else if (bus.mret_E) state_d = RET;
        else                 state_d = IDLE;
      end
      SAVE:  state_d = REDIR;
      REDIR: state_d = bus.redir_ready ? IDLE : REDIR;
      RET:   state_d = bus.redir_ready ? IDLE : RET;
      default: state_d = IDLE;
    endcase
  end

  logic               capture_s;
  logic [N-1:0]       epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [N-1:0]       redir_pc_q, redir_pc_d;
  logic               flush_q, stall_q, csr_we_q, redir_valid_q, busy_q;

  assign capture_s = (state_q == IDLE) && sel_valid_s;
  assign epc_d     = capture_s ? sel_pc_s : epc_q;
  assign cause_d   = capture_s ? sel_cause_s : cause_q;

  // Redirect target is frozen on entry so it stays stable until accepted.
  always_comb begin
    redir_pc_d = redir_pc_q;
    if (state_q == SAVE) begin
      redir_pc_d = {bus.mtvec[N-1:2], 2'b00};
    end else if ((state_q == IDLE) && (state_d == RET)) begin
      redir_pc_d = bus.mepc_q;
    end else begin
      redir_pc_d = redir_pc_q;
    end
  end

  // Captured trap record, redirect target and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q         <= '0;
      cause_q       <= 5'd0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      csr_we_q      <= 1'b0;
      redir_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= (state_d == SAVE) || ((state_d == RET) && (state_q == IDLE));
      stall_q       <= (state_d != IDLE);
      csr_we_q      <= (state_d == SAVE);
      redir_valid_q <= (state_d == REDIR) || (state_d == RET);
      busy_q        <= (state_d != IDLE);
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [N-1:0] tval_q, tval_d, tval_sel_s;

  // Memory faults report the data address, breakpoints their own pc.
  always_comb begin
    tval_sel_s = '0;
    if (sel_addr_s)                          tval_sel_s = bus.addr_E;
    else if (sel_cause_s == CAUSE_BREAKPOINT) tval_sel_s = sel_pc_s;
    else                                     tval_sel_s = '0;
  end

  assign tval_d = capture_s ? tval_sel_s : tval_q;

  // Trap value register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tval_q <= '0;
    else       tval_q <= tval_d;
  end

  assign bus.mtval_d = tval_q;
`else
  logic unused_s;
  assign unused_s    = &{1'b0, sel_addr_s, bus.addr_E};
  assign bus.mtval_d = '0;
`endif

  assign bus.flush       = flush_q;
  assign bus.stall       = stall_q;
  assign bus.csr_we      = csr_we_q;
  assign bus.mepc_d      = epc_q;
  assign bus.mcause_d    = {{(N-CAUSE_W){1'b0}}, cause_q};
  assign bus.redir_valid = redir_valid_q;
  assign bus.redir_pc    = redir_pc_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: driver pushes expected traps/redirects, monitor pops and compares.
module tb_trap_sequencer;
  import trap_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trap_sequencer_if #(.N(N)) bus();
  trap_sequencer #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] epc; logic [63:0] cause; logic [63:0] tval; int cyc; } trap_t;
  typedef struct { logic [63:0] pc; bit is_ret; int cyc; } redir_t;
  trap_t  trap_q[$];
  redir_t redir_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: scan stages oldest first, bits in architectural priority order.
  function automatic void model(input logic [6:0] ef, input logic [6:0] ed, input logic [6:0] ee,
                                input logic [63:0] pf, input logic [63:0] pd, input logic [63:0] pe,
                                input logic [63:0] addr, output bit hit, output logic [63:0] epc,
                                output logic [63:0] cause, output logic [63:0] tval);
    int prio[7];
    int code[7];
    logic [6:0]  vecs[3];
    logic [63:0] pcs[3];
    prio = '{6, 4, 5, 2, 0, 3, 1};
    code = '{4, 13, 6, 15, 2, 11, 3};
    vecs = '{ee, ed, ef};
    pcs  = '{pe, pd, pf};
    hit = 0; epc = 64'd0; cause = 64'd0; tval = 64'd0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 7; k++) begin
        if (!hit && vecs[s][prio[k]]) begin
          hit   = 1;
          epc   = pcs[s];
          cause = 64'(code[prio[k]]);
`ifdef TRAP_MTVAL_EN
          if (prio[k] <= 3)      tval = addr;
          else if (prio[k] == 6) tval = pcs[s];
          else                   tval = 64'd0;
`endif
        end
      end
    end
  endfunction

  // Monitor: compares every csr_we strobe and every redirect cycle against the queues.
  bit in_redir = 0;
  bit acc_pending = 0;
  always @(negedge clk) begin
    if (reset) begin
      in_redir    = 0;
      acc_pending = 0;
    end else begin
      if (acc_pending) begin
        check("valid_drop_after_accept", {63'd0, bus.redir_valid}, 64'd0);
        acc_pending = 0;
      end
      if (bus.csr_we) begin
        if (trap_q.size() == 0) begin
          check("unexpected_csr_we", 64'd1, 64'd0);
        end else begin
          trap_t t;
          t = trap_q.pop_front();
          check("mepc_d", bus.mepc_d, t.epc);
          check("mcause_d", bus.mcause_d, t.cause);
          check("mtval_d", bus.mtval_d, t.tval);
          check("csr_we_cycle", 64'(cyc), 64'(t.cyc));
          check("save_flush", {63'd0, bus.flush}, 64'd1);
          check("save_stall", {63'd0, bus.stall}, 64'd1);
        end
      end
      if (bus.redir_valid) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redir", 64'd1, 64'd0);
        end else begin
          check("redir_pc", bus.redir_pc, redir_q[0].pc);
          check("redir_stall", {63'd0, bus.stall}, 64'd1);
          if (!in_redir) begin
            check("redir_start_cycle", 64'(cyc), 64'(redir_q[0].cyc));
            check("redir_first_flush", {63'd0, bus.flush}, {63'd0, redir_q[0].is_ret});
          end else begin
            check("redir_hold_flush", {63'd0, bus.flush}, 64'd0);
          end
          in_redir = 1;
          if (bus.redir_ready) begin
            void'(redir_q.pop_front());
            in_redir    = 0;
            acc_pending = 1;
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.exc_F = 7'd0; bus.exc_D = 7'd0; bus.exc_E = 7'd0; bus.mret_E = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // One transaction; ready_delay < 0 leaves the redirect pending.
  task automatic issue(input logic [6:0] ef, input logic [6:0] ed, input logic [6:0] ee,
                       input logic [63:0] pf, input logic [63:0] pd, input logic [63:0] pe,
                       input logic [63:0] addr, input bit mret, input logic [63:0] mtvec,
                       input logic [63:0] mepc, input int ready_delay, input bit noise);
    bit hit;
    logic [63:0] epc, cause, tval;
    @(posedge clk); #1;
    wait_idle();
    bus.exc_F = ef; bus.exc_D = ed; bus.exc_E = ee;
    bus.pc_F = pf; bus.pc_D = pd; bus.pc_E = pe; bus.addr_E = addr;
    bus.mret_E = mret; bus.mtvec = mtvec; bus.mepc_q = mepc; bus.redir_ready = 1'b0;
    model(ef, ed, ee, pf, pd, pe, addr, hit, epc, cause, tval);
    if (hit) begin
      trap_q.push_back('{epc, cause, tval, cyc + 1});
      redir_q.push_back('{mtvec & ~64'h3, 1'b0, cyc + 2});
    end else if (mret) begin
      redir_q.push_back('{mepc, 1'b1, cyc + 1});
    end
    @(posedge clk); #1;
    clear_inputs();
    if (!hit && !mret) return;
    for (int i = 0; i < (ready_delay < 0 ? 3 : ready_delay); i++) begin
      if (noise) begin
        bus.exc_F = 7'($urandom); bus.exc_D = 7'($urandom);
        bus.exc_E = 7'h01 | 7'($urandom); bus.mret_E = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    if (ready_delay < 0) return;
    bus.redir_ready = 1'b1;
    wait_idle();
    bus.redir_ready = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [6:0] rnd_vec();
    return ($urandom_range(0, 2) == 0) ? 7'(1 << $urandom_range(0, 6)) :
           (($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom));
  endfunction

  initial begin
    clear_inputs();
    bus.pc_F = 64'd0; bus.pc_D = 64'd0; bus.pc_E = 64'd0; bus.addr_E = 64'd0;
    bus.mtvec = 64'd0; bus.mepc_q = 64'd0; bus.redir_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_redir_valid", {63'd0, bus.redir_valid}, 64'd0);
    check("rst_csr_we", {63'd0, bus.csr_we}, 64'd0);
    check("rst_mepc", bus.mepc_d, 64'd0);
    reset = 1'b0;

    issue(7'd0, 7'd0, 7'b0000001, 64'h100, 64'h200, 64'h400, 64'h1003, 1'b0, 64'h8000_0007, 64'd0, 2, 1'b0);
    issue(7'b0010000, 7'd0, 7'b0000100, 64'h104, 64'h208, 64'h40c, 64'h2000, 1'b0, 64'h8000_0100, 64'd0, 0, 1'b0);
    issue(7'd0, 7'b1010000, 7'd0, 64'h110, 64'h214, 64'h418, 64'h3000, 1'b1, 64'h8000_0202, 64'd0, 1, 1'b0);
    issue(7'd0, 7'd0, 7'd0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h8000_0000, 64'h800, 3, 1'b0);
    issue(7'd0, 7'd0, 7'b0001000, 64'h120, 64'h224, 64'h428, 64'h4444, 1'b0, 64'h8000_0301, 64'd0, 4, 1'b1);

    // Reset while a redirect is pending: everything drops at once.
    issue(7'd0, 7'd0, 7'b0100000, 64'h130, 64'h234, 64'h438, 64'h0, 1'b0, 64'h9000_0003, 64'd0, -1, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_redir_valid", {63'd0, bus.redir_valid}, 64'd0);
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_stall", {63'd0, bus.stall}, 64'd0);
    check("midrst_redir_pc", bus.redir_pc, 64'd0);
    check("midrst_mcause", bus.mcause_d, 64'd0);
    trap_q.delete();
    redir_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    issue(7'b1000000, 7'd0, 7'd0, 64'h140, 64'h244, 64'h448, 64'h5555, 1'b0, 64'h9000_0000, 64'd0, 1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(rnd_vec(), rnd_vec(), rnd_vec(), rnd64(), rnd64(), rnd64(), rnd64(),
            1'($urandom), rnd64(), rnd64(), $urandom_range(0, 4), 1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    check("trap_q_drained", 64'(trap_q.size()), 64'd0);
    check("redir_q_drained", 64'(redir_q.size()), 64'd0);
    check("final_busy", {63'd0, bus.busy}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
